// File: rtl/dmem_dump_unit_pkg.sv
// Shared definitions for the data-memory dump engine and the data-memory model.
package dmem_dump_unit_pkg;

  localparam int DMEM_ADDR_W = 6;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_dump_unit_if.sv
// Control, data-memory read port and output stream of the dump engine.
interface dmem_dump_unit_if
  import dmem_dump_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_W,
  parameter int DATA_WIDTH = DMEM_DATA_W
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  // master: requester side plus the memory returning read data
  modport master (
    output start, base_addr, word_count, mem_rdata, out_ready,
    input  mem_rd, mem_addr, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, mem_rdata, out_ready,
    output mem_rd, mem_addr, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/dmem_dump_unit.sv
// Reads a contiguous block of data memory and streams each word out with its
// address over valid/ready; the next word is prefetched during the handshake.
module dmem_dump_unit
  import dmem_dump_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_W,
  parameter int DATA_WIDTH = DMEM_DATA_W
) (
  input logic             Clk,
  input logic             reset,
  dmem_dump_unit_if.slave bus
);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   rem;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_valid, out_last;
  logic                  load, finish, accept;
  logic                  mem_rd, busy, done;
  logic [ADDR_WIDTH-1:0] mem_addr;

  always_ff @(posedge Clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    accept    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.word_count != '0) begin
            accept    = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = ptr;
        load      = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy     = 1'b1;
        mem_addr = ptr;
        // read only when the held word is about to leave and another follows
        mem_rd   = bus.out_ready & ~out_last;
        if (bus.out_ready) begin
          if (out_last) begin
            finish    = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      ptr       <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        ptr <= bus.base_addr;
        rem <= bus.word_count;
      end
      if (load) begin
        out_data  <= bus.mem_rdata;
        out_addr  <= ptr;
        out_last  <= (rem == (ADDR_WIDTH+1)'(1));
        out_valid <= 1'b1;
        ptr       <= ptr + 1'b1;
        rem       <= rem - 1'b1;
      end else if (finish) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.mem_rd    = mem_rd;
  assign bus.mem_addr  = mem_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_addr  = out_addr;
  assign bus.out_last  = out_last;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Directed bench for dmem_dump_unit with a combinational 64-word data-memory model.
module tb_dmem_dump_unit;
  import dmem_dump_unit_pkg::*;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  dmem_dump_unit_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  dmem_dump_unit #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr];

  function automatic logic [31:0] exp_word(input int a);
    case (a)
      4: return 32'h11;
      5: return 32'h22;
      6: return 32'h33;
      7: return 32'h44;
      default: return 32'hA000_0000 | 32'(a);
    endcase
  endfunction

  int total = 0;
  int bad   = 0;

  logic [5:0]  q_addr[$];
  logic [31:0] q_data[$];
  logic        q_last[$];
  int first_valid, done_cnt, done_idx, stall_rd, unstable, busy_low, rd_cnt;

  task automatic do_start(input logic [5:0] base, input logic [6:0] cnt);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = cnt;
    @(posedge Clk); #1;
    bus.start = 1'b0;
  endtask

  // Runs the stream until done or the cycle budget expires; k=0 is the FETCH cycle.
  task automatic collect(input int budget, input logic [15:0] pat, input int plen, input int inj_at);
    int vcyc = 0;
    bit held = 0;
    logic [31:0] hd;
    logic [5:0]  ha;
    logic        hl;
    q_addr.delete(); q_data.delete(); q_last.delete();
    first_valid = -1; done_cnt = 0; done_idx = -1;
    stall_rd = 0; unstable = 0; busy_low = 0; rd_cnt = 0;
    for (int k = 0; k < budget; k++) begin
      bus.out_ready = (vcyc < plen) ? pat[vcyc] : 1'b1;
      if (k == inj_at) begin
        bus.start = 1'b1; bus.base_addr = 6'd0; bus.word_count = 7'd4;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge Clk);
      if (bus.mem_rd) rd_cnt++;
      if (held) begin
        if (bus.out_data !== hd || bus.out_addr !== ha || bus.out_last !== hl || bus.out_valid !== 1'b1)
          unstable++;
        held = 0;
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = k;
        if (!bus.busy) busy_low++;
        if (bus.out_ready) begin
          q_addr.push_back(bus.out_addr);
          q_data.push_back(bus.out_data);
          q_last.push_back(bus.out_last);
        end else begin
          held = 1; hd = bus.out_data; ha = bus.out_addr; hl = bus.out_last;
          if (bus.mem_rd) stall_rd++;
        end
        vcyc++;
      end
      if (bus.done) begin done_cnt++; done_idx = k; end
      @(posedge Clk); #1;
      if (done_cnt > 0) break;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.mem_rd, bus.mem_addr, bus.busy, bus.done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h addr=%0d last=%b rd=%b maddr=%0d busy=%b done=%b, want all 0",
               bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.mem_rd, bus.mem_addr, bus.busy, bus.done);
    end
    @(posedge Clk); #1;
    reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_contiguous(input int inj_at, input string tag);
    logic [31:0] ed [4];
    ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33; ed[3] = 32'h44;
    do_start(6'd4, 7'd4);
    collect(20, 16'hFFFF, 16, inj_at);
    total++;
    if (first_valid != 1) begin bad++; $display("FAIL %s_latency: got %0d want 1", tag, first_valid); end
    total++;
    if (q_addr.size() != 4) begin bad++; $display("FAIL %s_count: got %0d want 4", tag, q_addr.size()); end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      total++;
      if (q_addr[i] !== 6'(4 + i) || q_data[i] !== ed[i] || q_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL %s_word%0d: got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                 tag, i, q_addr[i], q_data[i], q_last[i], 4 + i, ed[i], i == 3);
      end
    end
    total++;
    if (done_cnt != 1 || done_idx != 5) begin bad++; $display("FAIL %s_done: got cnt=%0d idx=%0d want 1/5", tag, done_cnt, done_idx); end
    total++;
    if (rd_cnt != 4 || busy_low != 0) begin bad++; $display("FAIL %s_rd_busy: got rd=%0d busy_low=%0d want 4/0", tag, rd_cnt, busy_low); end
    // a start pulsed while busy must not launch a second dump afterwards
    @(negedge Clk);
    total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_idle_after: got busy=%b valid=%b want 0/0", tag, bus.busy, bus.out_valid); end
    @(posedge Clk); #1;
  endtask

  task automatic test_backpressure;
    do_start(6'd4, 7'd4);
    collect(30, 16'h0069, 7, -1);
    total++;
    if (q_addr.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", q_addr.size()); end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      total++;
      if (q_addr[i] !== 6'(4 + i) || q_data[i] !== exp_word(4 + i) || q_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL bp_word%0d: got addr=%0d data=%h last=%b want addr=%0d data=%h", i, q_addr[i], q_data[i], q_last[i], 4 + i, exp_word(4 + i));
      end
    end
    total++;
    if (unstable != 0 || stall_rd != 0) begin bad++; $display("FAIL bp_stall: got unstable=%0d stall_rd=%0d want 0/0", unstable, stall_rd); end
    total++;
    if (done_cnt != 1 || done_idx != 8) begin bad++; $display("FAIL bp_done: got cnt=%0d idx=%0d want 1/8", done_cnt, done_idx); end
    total++;
    if (rd_cnt != 4) begin bad++; $display("FAIL bp_rd: got %0d want 4", rd_cnt); end
  endtask

  task automatic test_wrap;
    int ea [4];
    ea[0] = 62; ea[1] = 63; ea[2] = 0; ea[3] = 1;
    do_start(6'd62, 7'd4);
    collect(20, 16'hFFFF, 16, -1);
    total++;
    if (q_addr.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", q_addr.size()); end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      total++;
      if (q_addr[i] !== 6'(ea[i]) || q_data[i] !== exp_word(ea[i]) || q_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL wrap_word%0d: got addr=%0d data=%h want addr=%0d data=%h", i, q_addr[i], q_data[i], ea[i], exp_word(ea[i]));
      end
    end
  endtask

  task automatic test_edge_counts;
    int errs = 0;
    do_start(6'd5, 7'd0);
    collect(6, 16'hFFFF, 16, -1);
    total++;
    if (q_addr.size() != 0 || first_valid != -1 || rd_cnt != 0) begin
      bad++; $display("FAIL zero_stream: got words=%0d first_valid=%0d rd=%0d want 0/-1/0", q_addr.size(), first_valid, rd_cnt);
    end
    total++;
    if (done_cnt != 1 || done_idx < 0 || done_idx > 1) begin bad++; $display("FAIL zero_done: got cnt=%0d idx=%0d want one pulse", done_cnt, done_idx); end

    do_start(6'd0, 7'd64);
    collect(90, 16'hFFFF, 16, -1);
    total++;
    if (q_addr.size() != 64) begin bad++; $display("FAIL full_count: got %0d want 64", q_addr.size()); end
    for (int i = 0; i < 64 && i < q_addr.size(); i++)
      if (q_addr[i] !== 6'(i) || q_data[i] !== exp_word(i) || q_last[i] !== (i == 63)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL full_words: got %0d bad words want 0", errs); end
    total++;
    if (done_cnt != 1 || done_idx != 65) begin bad++; $display("FAIL full_done: got cnt=%0d idx=%0d want 1/65", done_cnt, done_idx); end
  endtask

  task automatic test_reset_mid;
    int hs = 0;
    int extra = 0;
    do_start(6'd10, 7'd8);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && hs < 2; k++) begin
      @(negedge Clk);
      if (bus.out_valid && bus.out_ready) hs++;
      @(posedge Clk); #1;
    end
    total++;
    if (hs != 2) begin bad++; $display("FAIL rst_mid_setup: got %0d handshakes want 2", hs); end
    reset = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b1;
    @(negedge Clk);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.mem_rd, bus.mem_addr, bus.busy, bus.done} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got valid=%b data=%h addr=%0d last=%b rd=%b maddr=%0d busy=%b done=%b, want all 0",
               bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.mem_rd, bus.mem_addr, bus.busy, bus.done);
    end
    @(posedge Clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (bus.done || bus.out_valid || bus.mem_rd) extra++;
      @(posedge Clk); #1;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", extra); end
    do_start(6'd20, 7'd3);
    collect(20, 16'hFFFF, 16, -1);
    total++;
    if (q_addr.size() != 3) begin bad++; $display("FAIL rst_mid_redump_count: got %0d want 3", q_addr.size()); end
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      total++;
      if (q_addr[i] !== 6'(20 + i) || q_data[i] !== exp_word(20 + i) || q_last[i] !== (i == 2)) begin
        bad++;
        $display("FAIL rst_mid_redump%0d: got addr=%0d data=%h want addr=%0d data=%h", i, q_addr[i], q_data[i], 20 + i, exp_word(20 + i));
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL rst_mid_redump_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = exp_word(i);
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.out_ready = 1'b1;
    test_reset();
    test_contiguous(-1, "contig");
    test_backpressure();
    test_wrap();
    test_edge_counts();
    test_reset_mid();
    test_contiguous(2, "ignstart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
